// File: rtl/if_id_stage_if.sv
// Handshake and result bundle between the IF/ID stage, the hazard unit,
// the instruction memory and the decode stage.
interface if_id_stage_if;
  logic        pc_wr_en;
  logic        ifid_wr_en;
  logic        bubble_sel;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        id_bubble;
  logic [15:0] stall_count;

  modport master (
    output pc_wr_en, ifid_wr_en, bubble_sel, branch_taken, branch_target,
           imem_valid, imem_rdata,
    input  imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
           id_bubble, stall_count
  );

  modport slave (
    input  pc_wr_en, ifid_wr_en, bubble_sel, branch_taken, branch_target,
           imem_valid, imem_rdata,
    output imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
           id_bubble, stall_count
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage with PC, IF/ID pipeline register, one-entry hold buffer for
// words that arrive during a stall, and a saturating stall counter.
//
// state | meaning
// IDLE  | single cycle after reset release, no fetch issued
// FETCH | fetch request for the PC outstanding every cycle
// HOLD  | fetched word parked in the hold buffer until both enables return
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic          clk,
  input  logic          reset,
  if_id_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } stateT;

  stateT       stateQ, stateN;
  logic [31:0] pcQ, pcN;
  logic [31:0] instrQ, instrN;
  logic [31:0] pcPlus4Q, pcPlus4N;
  logic        validQ, validN;
  logic [31:0] holdQ, holdN;
  logic        bubbleQ;
  logic [15:0] stallCntQ;

  logic [31:0] pcInc;
  logic        advance;
  logic        stallCycle;

  assign pcInc   = pcQ + 32'd4;
  // An IF/ID hold with the PC enabled still counts as a stall: PC only moves with a load.
  assign advance = bus.pc_wr_en & bus.ifid_wr_en;
  assign stallCycle = ~bus.pc_wr_en | ~bus.ifid_wr_en |
                      ((stateQ == FETCH) & ~bus.imem_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ    <= IDLE;
      pcQ       <= RESET_PC;
      instrQ    <= NOP_INSTR;
      pcPlus4Q  <= 32'd0;
      validQ    <= 1'b0;
      holdQ     <= 32'd0;
      bubbleQ   <= 1'b0;
      stallCntQ <= 16'd0;
    end else begin
      stateQ   <= stateN;
      pcQ      <= pcN;
      instrQ   <= instrN;
      pcPlus4Q <= pcPlus4N;
      validQ   <= validN;
      holdQ    <= holdN;
      bubbleQ  <= bus.bubble_sel | bus.branch_taken;
      if (stallCycle && stallCntQ != 16'hFFFF)
        stallCntQ <= stallCntQ + 16'd1;
    end
  end

  always_comb begin
    stateN   = stateQ;
    pcN      = pcQ;
    instrN   = instrQ;
    pcPlus4N = pcPlus4Q;
    validN   = validQ;
    holdN    = holdQ;

    if (bus.branch_taken) begin
      // Redirect wins over everything, including a word arriving this cycle.
      stateN = FETCH;
      pcN    = bus.branch_target;
      instrN = NOP_INSTR;
      validN = 1'b0;
      holdN  = 32'd0;
    end else begin
      case (stateQ)
        IDLE: stateN = FETCH;
        FETCH: begin
          if (bus.imem_valid) begin
            if (advance) begin
              instrN   = bus.imem_rdata;
              pcPlus4N = pcInc;
              validN   = 1'b1;
              pcN      = pcInc;
            end else begin
              holdN  = bus.imem_rdata;
              stateN = HOLD;
            end
          end else if (bus.ifid_wr_en) begin
            validN = 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            instrN   = holdQ;
            pcPlus4N = pcInc;
            validN   = 1'b1;
            pcN      = pcInc;
            stateN   = FETCH;
          end
        end
        default: stateN = IDLE;
      endcase
    end
  end

  assign bus.imem_req      = (stateQ == FETCH);
  assign bus.imem_addr     = pcQ;
  assign bus.ifid_instr    = instrQ;
  assign bus.ifid_pc_plus4 = pcPlus4Q;
  assign bus.ifid_valid    = validQ;
  assign bus.id_bubble     = bubbleQ;
  assign bus.stall_count   = stallCntQ;

endmodule
